// File: rtl/tiny_alu_pkg.sv
// tiny_alu_pkg: shared opcodes, defaults and result record
// for the tiny ALU pipeline.
package tiny_alu_pkg;

  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_OPCODE_BITS  = 3;
  localparam int DEF_PIPE_LATENCY = 3;
  localparam int DEF_FIFO_DEPTH   = 4;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_AND = 3'd2,
    OP_XOR = 3'd3,
    OP_MUL = 3'd4
  } op_e;

  typedef struct packed {
    logic                         err;
    logic [2*DEF_DATA_BITS-1:0]   result;
  } res_t;

endpackage

// File: rtl/tiny_alu_pipe_if.sv
// tiny_alu_pipe_if: clock/reset bundle and request/result
// handshake bundle for the tiny ALU pipeline.
interface tiny_clk_rst_if;
  logic clk_i;
  logic rst_i;

  modport master (output clk_i, output rst_i);
  modport slave  (input clk_i, input rst_i);
endinterface

interface tiny_alu_pipe_if #(
  parameter int DATA_BITS   = 8,
  parameter int OPCODE_BITS = 3
);
  logic                     start_i;
  logic                     ready_o;
  logic [OPCODE_BITS-1:0]   opcode_i;
  logic [DATA_BITS-1:0]     a_i;
  logic [DATA_BITS-1:0]     b_i;
  logic                     done_o;
  logic [2*DATA_BITS-1:0]   result_o;
  logic                     err_o;
  logic                     result_ready_i;

  modport master (
    output start_i, opcode_i, a_i, b_i, result_ready_i,
    input  ready_o, done_o, result_o, err_o
  );
  modport slave (
    input  start_i, opcode_i, a_i, b_i, result_ready_i,
    output ready_o, done_o, result_o, err_o
  );
endinterface

// File: rtl/tiny_alu_result_fifo.sv
// tiny_alu_result_fifo: output queue holding finished results
// in order; pointers wrap modulo DEPTH.
module tiny_alu_result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // pointer and occupancy update
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = nxt(wr_q);
    if (do_pop)  rd_d = nxt(rd_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // control state, cleared by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage needs no reset; occupancy qualifies it
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o && !pop_i)
  );

endmodule

// File: rtl/tiny_alu_pipe.sv
// tiny_alu_pipe: credit-limited fixed-latency ALU with an
// in-order result queue; MUL is spread over the stages.
module tiny_alu_pipe
  import tiny_alu_pkg::*;
#(
  parameter int INPUT_DATA_BITS = DEF_DATA_BITS,
  parameter int OPCODE_BITS     = DEF_OPCODE_BITS,
  parameter int PIPE_LATENCY    = DEF_PIPE_LATENCY,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
  tiny_clk_rst_if.slave  clk_rst_if,
  tiny_alu_pipe_if.slave bus_if
);

  localparam int W  = INPUT_DATA_BITS;
  localparam int OB = OPCODE_BITS;
  localparam int L  = PIPE_LATENCY;
  localparam int D  = FIFO_DEPTH;
  localparam int W2 = 2 * W;
  localparam int CH = (W + L - 1) / L;
  localparam int CW = $clog2(D + 1);

  localparam logic [OB-1:0] C_NOP = OB'(OP_NOP);
  localparam logic [OB-1:0] C_ADD = OB'(OP_ADD);
  localparam logic [OB-1:0] C_AND = OB'(OP_AND);
  localparam logic [OB-1:0] C_XOR = OB'(OP_XOR);
  localparam logic [OB-1:0] C_MUL = OB'(OP_MUL);

  typedef struct packed {
    logic          err;
    logic [W2-1:0] result;
  } res_w_t;

  logic          clk;
  logic          rst;
  logic          ready;
  logic          accept;
  logic          acc_op;
  logic          pop;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [L-1:0]  vld_q, vld_d;
  logic [OB-1:0] op_q  [L];
  logic [OB-1:0] op_d  [L];
  logic [W-1:0]  a_q   [L];
  logic [W-1:0]  a_d   [L];
  logic [W-1:0]  b_q   [L];
  logic [W-1:0]  b_d   [L];
  logic [W2-1:0] acc_q [L];
  logic [W2-1:0] acc_d [L];
  res_w_t        res_in;
  res_w_t        res_out;
  logic          f_full;
  logic          f_empty;
  logic [CW-1:0] f_count;

  // partial product of a with the j-th CH-bit slice of b
  function automatic logic [W2-1:0] pp(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input int           j
  );
    logic [W2-1:0] aw, bw, m;
    aw = {{W{1'b0}}, a};
    bw = {{W{1'b0}}, b} >> (j * CH);
    m  = ~({W2{1'b1}} << CH);
    return (aw * (bw & m)) << (j * CH);
  endfunction

  assign clk    = clk_rst_if.clk_i;
  assign rst    = clk_rst_if.rst_i;
  assign ready  = ~rst & (cnt_q < CW'(D));
  assign accept = bus_if.start_i & ready;
  assign acc_op = accept & (bus_if.opcode_i != C_NOP);
  assign pop    = ~f_empty & bus_if.result_ready_i;

  assign bus_if.ready_o  = ready;
  assign bus_if.done_o   = ~f_empty;
  assign bus_if.result_o = f_empty ? '0 : res_out.result;
  assign bus_if.err_o    = ~f_empty & res_out.err;

  // credits: in-flight plus queued results
  always_comb begin
    cnt_d = cnt_q + CW'(acc_op) - CW'(pop);
  end

  // valid shift and MUL accumulation across stages
  always_comb begin
    vld_d[0] = acc_op;
    op_d[0]  = acc_op ? bus_if.opcode_i : op_q[0];
    a_d[0]   = acc_op ? bus_if.a_i : a_q[0];
    b_d[0]   = acc_op ? bus_if.b_i : b_q[0];
    acc_d[0] = acc_op ? pp(bus_if.a_i, bus_if.b_i, 0)
                      : acc_q[0];
    for (int i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1];
      op_d[i]  = op_q[i-1];
      a_d[i]   = a_q[i-1];
      b_d[i]   = b_q[i-1];
      acc_d[i] = acc_q[i-1] + pp(a_q[i-1], b_q[i-1], i);
    end
  end

  // final stage result select
  always_comb begin
    res_in = '0;
    unique case (1'b1)
      op_q[L-1] == C_ADD:
        res_in.result = W2'({1'b0, a_q[L-1]} + {1'b0, b_q[L-1]});
      op_q[L-1] == C_AND:
        res_in.result = W2'(a_q[L-1] & b_q[L-1]);
      op_q[L-1] == C_XOR:
        res_in.result = W2'(a_q[L-1] ^ b_q[L-1]);
      op_q[L-1] == C_MUL:
        res_in.result = acc_q[L-1];
      default:
        res_in.err = 1'b1;
    endcase
  end

  // credit counter and stage valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  // stage data, qualified by the valids
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

  tiny_alu_result_fifo #(
    .WIDTH ($bits(res_w_t)),
    .DEPTH (D)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (vld_q[L-1]),
    .data_i  (res_in),
    .pop_i   (pop),
    .data_o  (res_out),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  a_credit_covers_queue: assert property (
    @(posedge clk) disable iff (rst)
    (cnt_q >= f_count) && (!f_full || cnt_q == CW'(D))
  );

endmodule

// File: tb/tb_tiny_alu_pipe.sv
// tb_tiny_alu_pipe: vector table, directed corner sequences
// and random traffic against a queue-based reference model.
module tb_tiny_alu_pipe;
  import tiny_alu_pkg::*;

  localparam int L = 3;
  localparam int D = 4;

  tiny_clk_rst_if cr ();
  tiny_alu_pipe_if #(.DATA_BITS(8), .OPCODE_BITS(3)) bi ();

  tiny_alu_pipe #(
    .INPUT_DATA_BITS (8),
    .OPCODE_BITS     (3),
    .PIPE_LATENCY    (L),
    .FIFO_DEPTH      (D)
  ) dut (
    .clk_rst_if (cr),
    .bus_if     (bi)
  );

  initial cr.clk_i = 1'b0;
  always #5 cr.clk_i = ~cr.clk_i;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          arrive;
  } exp_t;

  typedef struct {
    int          op;
    int          a;
    int          b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  exp_t        pend[$];
  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  int          acc_cnt = 0;
  logic        obs_done;
  logic [15:0] obs_res;
  logic        obs_err;

  task automatic check(input string nm, input longint act,
                       input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input int op, input int a,
                                 input int b);
    exp_t e;
    int   r;
    e.err = 1'b0;
    r = 0;
    case (op)
      1: r = a + b;
      2: r = a & b;
      3: r = a ^ b;
      4: r = a * b;
      default: e.err = 1'b1;
    endcase
    e.res = r[15:0];
    e.arrive = 0;
    return e;
  endfunction

  // called at a falling edge; returns at the next falling edge
  task automatic cycle(input bit st, input int op, input int a,
                       input int b, input bit rr);
    bit   exp_ready, exp_done, acc, pp;
    exp_t e;
    bi.start_i        = st;
    bi.opcode_i       = op[2:0];
    bi.a_i            = a[7:0];
    bi.b_i            = b[7:0];
    bi.result_ready_i = rr;
    #1;
    exp_ready = (pend.size() < D);
    exp_done  = (pend.size() > 0) && (pend[0].arrive <= edge_n);
    check("ready_o", bi.ready_o, exp_ready);
    check("done_o", bi.done_o, exp_done);
    if (exp_done) begin
      check("result_o", bi.result_o, pend[0].res);
      check("err_o", bi.err_o, pend[0].err);
    end
    obs_done = bi.done_o;
    obs_res  = bi.result_o;
    obs_err  = bi.err_o;
    acc = st && exp_ready;
    pp  = exp_done && rr;
    if (acc) acc_cnt++;
    @(posedge cr.clk_i);
    edge_n++;
    if (pp) void'(pend.pop_front());
    if (acc && op != 0) begin
      e = model(op, a, b);
      e.arrive = edge_n + L;
      pend.push_back(e);
    end
    @(negedge cr.clk_i);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, rr);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ready"}, bi.ready_o, 0);
    check({nm, "_done"}, bi.done_o, 0);
    check({nm, "_result"}, bi.result_o, 0);
    check({nm, "_err"}, bi.err_o, 0);
  endtask

  initial begin
    vec_t vt[8];
    int   lat;
    int   got_res[$];
    int   got_cyc[$];
    int   n_done;

    vt[0] = '{1, 8'hFF, 8'h01, 16'h0100, 1'b0};
    vt[1] = '{4, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vt[2] = '{2, 8'hF0, 8'h3C, 16'h0030, 1'b0};
    vt[3] = '{3, 8'hF0, 8'h3C, 16'h00CC, 1'b0};
    vt[4] = '{7, 8'h12, 8'h34, 16'h0000, 1'b1};
    vt[5] = '{5, 8'hAA, 8'h55, 16'h0000, 1'b1};
    vt[6] = '{4, 8'h81, 8'h7F, 16'h3FFF, 1'b0};
    vt[7] = '{1, 8'h00, 8'h00, 16'h0000, 1'b0};

    cr.rst_i          = 1'b1;
    bi.start_i        = 1'b0;
    bi.opcode_i       = '0;
    bi.a_i            = '0;
    bi.b_i            = '0;
    bi.result_ready_i = 1'b0;
    repeat (2) @(negedge cr.clk_i);
    #1;
    check_reset_outputs("por");
    @(negedge cr.clk_i);
    cr.rst_i = 1'b0;

    // table vectors: value and 3-edge latency
    foreach (vt[i]) begin
      cycle(1, vt[i].op, vt[i].a, vt[i].b, 1);
      lat = 99;
      for (int k = 0; k < 10; k++) begin
        cycle(0, 0, 0, 0, 1);
        if (obs_done) begin
          lat = k;
          break;
        end
      end
      check($sformatf("vec%0d_lat", i), lat, 3);
      check($sformatf("vec%0d_res", i), obs_res, vt[i].res);
      check($sformatf("vec%0d_err", i), obs_err, vt[i].err);
      idle(2, 1);
    end

    // NOP gives no result
    cycle(1, 0, 8'h11, 8'h22, 1);
    n_done = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (obs_done) n_done++;
    end
    check("nop_no_done", n_done, 0);

    // back-to-back, results on consecutive cycles
    cycle(1, 1, 1, 2, 1);
    cycle(1, 3, 5, 3, 1);
    cycle(1, 2, 6, 3, 1);
    cycle(1, 4, 4, 4, 1);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (obs_done) begin
        got_res.push_back(int'(obs_res));
        got_cyc.push_back(k);
      end
    end
    check("b2b_count", got_res.size(), 4);
    if (got_res.size() == 4) begin
      check("b2b_r0", got_res[0], 3);
      check("b2b_r1", got_res[1], 6);
      check("b2b_r2", got_res[2], 2);
      check("b2b_r3", got_res[3], 16);
      check("b2b_consec", got_cyc[3] - got_cyc[0], 3);
    end

    // backpressure: 6 offered, 4 accepted, then drain
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) cycle(1, 1, i, 16 * i, 0);
    check("bp_accepted", acc_cnt, 4);
    idle(4, 0);
    check("bp_ready_low", bi.ready_o, 0);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (obs_done) n_done++;
    end
    check("bp_drained", n_done, 4);

    // full queue: pop and new accepts overlap
    for (int i = 0; i < 4; i++) cycle(1, 4, 8'hF0 + i, 8'h0F, 0);
    idle(3, 0);
    for (int i = 0; i < 10; i++) cycle(1, 3, i, 8'h5A, 1);
    idle(8, 1);

    // reset with 2 in flight and 1 queued
    cycle(1, 1, 1, 1, 0);
    cycle(1, 2, 3, 3, 0);
    cycle(1, 4, 9, 9, 0);
    cycle(0, 0, 0, 0, 0);
    check("mid_queued", bi.done_o, 1);
    cr.rst_i = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    pend.delete();
    repeat (2) @(negedge cr.clk_i);
    #1;
    check_reset_outputs("mid_hold");
    @(negedge cr.clk_i);
    cr.rst_i = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(0, 0, 0, 0, 1);
      if (obs_done) n_done++;
    end
    check("post_rst_no_done", n_done, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 3) != 0);
    end
    idle(12, 1);
    check("final_empty", bi.done_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
